tick_bcd_counter: RTL and testbench

Downstream consumer of the enable-gated clock divider. It samples the divider's level output in the `clk` domain and detects rising edges, so each divided period yields exactly one count. On each edge it advances a multi-digit BCD counter, up or down, that wraps at a programmable decimal modulus. The counter value feeds display logic for timers, stopwatches and similar designs.

---
 rtl/tick_pkg.sv | 52 +++++
 rtl/bcd_digit.sv | 48 ++++
 rtl/tick_bcd_counter.sv | 125 ++++++++++++
 tb/tb_tick_bcd_counter.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/tick_pkg.sv
// Shared types, 7-segment patterns and elaboration helpers for tick_bcd_counter.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package tick_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam int MAX_DIGITS = 4;

  localparam logic [6:0] SEG7_0     = 7'h40;
  localparam logic [6:0] SEG7_1     = 7'h79;
  localparam logic [6:0] SEG7_2     = 7'h24;
  localparam logic [6:0] SEG7_3     = 7'h30;
  localparam logic [6:0] SEG7_4     = 7'h19;
  localparam logic [6:0] SEG7_5     = 7'h12;
  localparam logic [6:0] SEG7_6     = 7'h02;
  localparam logic [6:0] SEG7_7     = 7'h78;
  localparam logic [6:0] SEG7_8     = 7'h00;
  localparam logic [6:0] SEG7_9     = 7'h10;
  localparam logic [6:0] SEG7_BLANK = 7'h7F;

  // Binary integer to packed BCD, nibble 0 least significant.
  function automatic logic [4*MAX_DIGITS-1:0] to_bcd(input int value);
    int v;
    logic [4*MAX_DIGITS-1:0] r;
    v = value;
    r = {(4*MAX_DIGITS){1'b0}};
    for (int i = 0; i < MAX_DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [6:0] seg7_decode(input bcd_digit_t d);
    logic [6:0] s;
    case (d)
      4'd0:    s = SEG7_0;
      4'd1:    s = SEG7_1;
      4'd2:    s = SEG7_2;
      4'd3:    s = SEG7_3;
      4'd4:    s = SEG7_4;
      4'd5:    s = SEG7_5;
      4'd6:    s = SEG7_6;
      4'd7:    s = SEG7_7;
      4'd8:    s = SEG7_8;
      4'd9:    s = SEG7_9;
      default: s = SEG7_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decimal digit (0..9) with up/down stepping, parallel load and clear.
// Priority: clr, load, inc, dec.
module bcd_digit
  import tick_pkg::*;
(
  input  logic       clk,
  input  logic       _rst,
  input  logic       inc,
  input  logic       dec,
  input  logic       load,
  input  bcd_digit_t ld_val,
  input  logic       clr,
  output bcd_digit_t val,
  output logic       at9,
  output logic       at0
);

  bcd_digit_t nxt;

  // Next digit value; each digit wraps 9<->0 on its own.
  always_comb begin
    nxt = val;
    if (clr) begin
      nxt = 4'd0;
    end else if (load) begin
      nxt = ld_val;
    end else if (inc) begin
      nxt = (val == 4'd9) ? 4'd0 : val + 4'd1;
    end else if (dec) begin
      nxt = (val == 4'd0) ? 4'd9 : val - 4'd1;
    end else begin
      nxt = val;
    end
  end

  // Digit register.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      val <= 4'd0;
    end else begin
      val <= nxt;
    end
  end

  assign at9 = (val == 4'd9);
  assign at0 = (val == 4'd0);

endmodule

// File: rtl/tick_bcd_counter.sv
// Multi-digit up/down BCD counter advanced by rising edges of a divided-clock level.
// Optional 7-segment outputs are built when TICK_SEG7_EN is defined.
module tick_bcd_counter
  import tick_pkg::*;
#(
  parameter int DIGITS  = 2,
  parameter int MAX_VAL = 59
) (
  input  logic                clk,
  input  logic                _rst,
  input  logic                tick_in,
  input  logic                en,
  input  logic                up,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  output logic [4*DIGITS-1:0] bcd,
  output logic                carry,
  output logic                load_err
`ifdef TICK_SEG7_EN
  ,
  output logic [7*DIGITS-1:0] seg
`endif
);

  localparam int W = 4 * DIGITS;
  localparam logic [4*MAX_DIGITS-1:0] MAX_BCD_FULL = to_bcd(MAX_VAL);
  localparam logic [W-1:0] MAX_BCD = MAX_BCD_FULL[W-1:0];

  logic              tick_d;
  logic              rise;
  logic              count;
  logic              at_max;
  logic              at_zero;
  logic              wrap_up;
  logic              wrap_dn;
  logic              step_up;
  logic              step_dn;
  logic              nib_ok;
  logic              load_ok;
  logic              dig_load;
  logic [W-1:0]      dig_ld_val;
  logic [DIGITS-1:0] at9;
  logic [DIGITS-1:0] at0;
  logic [DIGITS-1:0] inc_vec;
  logic [DIGITS-1:0] dec_vec;
  logic              run9;
  logic              run0;

  // Edge detector history; resets high so a level already high at release is not an edge.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      tick_d <= 1'b1;
    end else begin
      tick_d <= tick_in;
    end
  end

  assign rise    = tick_in & ~tick_d;
  assign count   = en & rise & ~load;
  assign at_max  = (bcd == MAX_BCD);
  assign at_zero = (bcd == {W{1'b0}});
  assign wrap_up = count & up & at_max;
  assign wrap_dn = count & ~up & at_zero;
  assign step_up = count & up & ~at_max;
  assign step_dn = count & ~up & ~at_zero;

  // Load validation: valid BCD nibbles compare correctly as a plain unsigned vector.
  always_comb begin
    nib_ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      nib_ok = nib_ok & (load_val[4*i +: 4] <= 4'd9);
    end
    load_ok = nib_ok & (load_val <= MAX_BCD);
  end

  // Carry chain; the terminal compare already removed wrapping steps from step_up/step_dn.
  always_comb begin
    run9    = 1'b1;
    run0    = 1'b1;
    inc_vec = {DIGITS{1'b0}};
    dec_vec = {DIGITS{1'b0}};
    for (int i = 0; i < DIGITS; i++) begin
      inc_vec[i] = step_up & run9;
      dec_vec[i] = step_dn & run0;
      run9       = run9 & at9[i];
      run0       = run0 & at0[i];
    end
  end

  assign dig_load   = (load & load_ok) | wrap_dn;
  assign dig_ld_val = load ? load_val : MAX_BCD;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_digit
      bcd_digit u_digit (
        .clk    (clk),
        ._rst   (_rst),
        .inc    (inc_vec[g]),
        .dec    (dec_vec[g]),
        .load   (dig_load),
        .ld_val (dig_ld_val[4*g +: 4]),
        .clr    (wrap_up),
        .val    (bcd[4*g +: 4]),
        .at9    (at9[g]),
        .at0    (at0[g])
      );
`ifdef TICK_SEG7_EN
      assign seg[7*g +: 7] = seg7_decode(bcd[4*g +: 4]);
`endif
    end
  endgenerate

  // Single-cycle status pulses.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      carry    <= 1'b0;
      load_err <= 1'b0;
    end else begin
      carry    <= wrap_up | wrap_dn;
      load_err <= load & ~load_ok;
    end
  end

endmodule

// File: tb/tb_tick_bcd_counter.sv
// Directed self-checking bench for tick_bcd_counter (DIGITS=2, MAX_VAL=59).
module tb_tick_bcd_counter;
  import tick_pkg::*;

  logic       clk;
  logic       _rst;
  logic       tick_in;
  logic       en;
  logic       up;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] bcd;
  logic       carry;
  logic       load_err;
`ifdef TICK_SEG7_EN
  logic [13:0] seg;
`endif

  int errors = 0;
  int checks = 0;

  tick_bcd_counter #(.DIGITS(2), .MAX_VAL(59)) dut (
    .clk      (clk),
    ._rst     (_rst),
    .tick_in  (tick_in),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .bcd      (bcd),
    .carry    (carry),
    .load_err (load_err)
`ifdef TICK_SEG7_EN
    ,
    .seg      (seg)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] dec2bcd(input int n);
    logic [3:0] hi;
    logic [3:0] lo;
    hi = 4'(n / 10);
    lo = 4'(n % 10);
    return {hi, lo};
  endfunction

  task automatic do_load(input logic [7:0] v);
    load_val = v;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic test_reset;
    _rst = 1'b0; tick_in = 1'b1; en = 1'b1; up = 1'b1; load = 1'b0; load_val = 8'h00;
    repeat (3) @(negedge clk);
    checks++; if (bcd !== 8'h00) begin errors++; $display("FAIL reset_bcd: got %h want %h", bcd, 8'h00); end
    checks++; if (carry !== 1'b0 || load_err !== 1'b0) begin errors++; $display("FAIL reset_pulses: got carry=%b load_err=%b want 0 0", carry, load_err); end
    _rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bcd !== 8'h00) begin errors++; $display("FAIL reset_release_high: got %h want %h", bcd, 8'h00); end
    tick_in = 1'b0; @(negedge clk);
    tick_in = 1'b1; @(negedge clk);
    checks++; if (bcd !== 8'h01) begin errors++; $display("FAIL first_count: got %h want %h", bcd, 8'h01); end
    repeat (3) @(negedge clk);
    checks++; if (bcd !== 8'h01) begin errors++; $display("FAIL long_high: got %h want %h", bcd, 8'h01); end
    tick_in = 1'b0; @(negedge clk);
  endtask

  task automatic test_up_wrap;
    up = 1'b1; en = 1'b1;
    do_load(8'h00);
    checks++; if (bcd !== 8'h00) begin errors++; $display("FAIL up_start: got %h want %h", bcd, 8'h00); end
    for (int n = 1; n <= 59; n++) begin
      tick_in = 1'b1; @(negedge clk);
      checks++; if (bcd !== dec2bcd(n) || carry !== 1'b0) begin errors++; $display("FAIL up_step%0d: got bcd=%h carry=%b want bcd=%h carry=0", n, bcd, carry, dec2bcd(n)); end
      tick_in = 1'b0; @(negedge clk);
    end
    tick_in = 1'b1; @(negedge clk);
    checks++; if (bcd !== 8'h00 || carry !== 1'b1) begin errors++; $display("FAIL up_wrap: got bcd=%h carry=%b want bcd=00 carry=1", bcd, carry); end
    tick_in = 1'b0; @(negedge clk);
    checks++; if (carry !== 1'b0) begin errors++; $display("FAIL up_wrap_carry_len: got %b want 0", carry); end
  endtask

  task automatic test_down_wrap;
    up = 1'b0; en = 1'b1;
    tick_in = 1'b1; @(negedge clk);
    checks++; if (bcd !== 8'h59 || carry !== 1'b1) begin errors++; $display("FAIL down_wrap: got bcd=%h carry=%b want bcd=59 carry=1", bcd, carry); end
    tick_in = 1'b0; @(negedge clk);
    checks++; if (carry !== 1'b0) begin errors++; $display("FAIL down_wrap_carry_len: got %b want 0", carry); end
    tick_in = 1'b1; @(negedge clk);
    checks++; if (bcd !== 8'h58 || carry !== 1'b0) begin errors++; $display("FAIL down_step: got bcd=%h carry=%b want bcd=58 carry=0", bcd, carry); end
    tick_in = 1'b0; @(negedge clk);
    do_load(8'h10);
    tick_in = 1'b1; @(negedge clk);
    checks++; if (bcd !== 8'h09 || carry !== 1'b0) begin errors++; $display("FAIL down_borrow: got bcd=%h carry=%b want bcd=09 carry=0", bcd, carry); end
    tick_in = 1'b0; @(negedge clk);
  endtask

  task automatic test_load;
    up = 1'b1; en = 1'b1;
    do_load(8'h42);
    checks++; if (bcd !== 8'h42 || load_err !== 1'b0) begin errors++; $display("FAIL load_42: got bcd=%h load_err=%b want bcd=42 load_err=0", bcd, load_err); end
    do_load(8'h1A);
    checks++; if (bcd !== 8'h42 || load_err !== 1'b1) begin errors++; $display("FAIL load_1A: got bcd=%h load_err=%b want bcd=42 load_err=1", bcd, load_err); end
    @(negedge clk);
    checks++; if (load_err !== 1'b0) begin errors++; $display("FAIL load_err_len: got %b want 0", load_err); end
    do_load(8'h60);
    checks++; if (bcd !== 8'h42 || load_err !== 1'b1) begin errors++; $display("FAIL load_60: got bcd=%h load_err=%b want bcd=42 load_err=1", bcd, load_err); end
    do_load(8'h59);
    checks++; if (bcd !== 8'h59 || load_err !== 1'b0) begin errors++; $display("FAIL load_max: got bcd=%h load_err=%b want bcd=59 load_err=0", bcd, load_err); end
    tick_in = 1'b1; load_val = 8'h30; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    checks++; if (bcd !== 8'h30 || carry !== 1'b0) begin errors++; $display("FAIL load_vs_rise: got bcd=%h carry=%b want bcd=30 carry=0", bcd, carry); end
    tick_in = 1'b0; @(negedge clk);
    en = 1'b0;
    do_load(8'h07);
    checks++; if (bcd !== 8'h07) begin errors++; $display("FAIL load_en_low: got %h want %h", bcd, 8'h07); end
    en = 1'b1;
  endtask

  task automatic test_enable;
    up = 1'b1;
    do_load(8'h25);
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick_in = 1'b1; @(negedge clk);
      tick_in = 1'b0; @(negedge clk);
    end
    checks++; if (bcd !== 8'h25) begin errors++; $display("FAIL en_frozen: got %h want %h", bcd, 8'h25); end
    tick_in = 1'b1; @(negedge clk);
    en = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bcd !== 8'h25) begin errors++; $display("FAIL en_rearm: got %h want %h", bcd, 8'h25); end
    tick_in = 1'b0; @(negedge clk);
    tick_in = 1'b1; @(negedge clk);
    checks++; if (bcd !== 8'h26) begin errors++; $display("FAIL en_resume: got %h want %h", bcd, 8'h26); end
    tick_in = 1'b0; @(negedge clk);
  endtask

  task automatic test_reset_mid;
    do_load(8'h33);
    tick_in = 1'b1;
    #2;
    _rst = 1'b0;
    #1;
    checks++; if (bcd !== 8'h00 || carry !== 1'b0) begin errors++; $display("FAIL async_reset: got bcd=%h carry=%b want bcd=00 carry=0", bcd, carry); end
    @(negedge clk);
    _rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bcd !== 8'h00) begin errors++; $display("FAIL reset_no_pending: got %h want %h", bcd, 8'h00); end
    tick_in = 1'b0; @(negedge clk);
  endtask

`ifdef TICK_SEG7_EN
  task automatic test_seg7;
    logic [13:0] exp_seg;
    exp_seg = {SEG7_3, SEG7_7};
    do_load(8'h37);
    checks++; if (bcd !== 8'h37 || seg !== exp_seg) begin errors++; $display("FAIL seg7_37: got bcd=%h seg=%h want bcd=37 seg=%h", bcd, seg, exp_seg); end
  endtask
`endif

  initial begin
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_load();
    test_enable();
    test_reset_mid();
`ifdef TICK_SEG7_EN
    test_seg7();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
